// File: rtl/timed_sel_mux.sv
// timed_sel_mux
//   N:1 registered multiplexer with a round-robin dwell sequencer. Each channel
//   is held for max(dwell[k],1) cycles, then the next channel is selected
//   (wrapping NCH-1 -> 0). A forced jump may override the sequence at any time.
//   Optional macro TSM_GAP_INSERT_EN inserts a GAP_CYC-cycle all-zero clearance
//   gap before every switch made while running.
// Ports
//   clk, rst_n   : rising-edge clock, synchronous active-low reset
//   en           : 1 runs the sequencer, 0 returns to IDLE
//   din          : channel k at din[k*WIDTH +: WIDTH]
//   dwell        : channel k dwell at dwell[k*CNTW +: CNTW]
//   force_vld    : one-cycle jump request to force_sel (ignored if >= NCH)
//   dout         : registered pattern of the selected channel (1-cycle latency)
//   sel          : currently selected channel
//   switch_pulse : high in the first cycle of a new sel
module timed_sel_mux #(
  parameter int WIDTH   = 5,
  parameter int NCH     = 4,
  parameter int SELW    = 2,
  parameter int CNTW    = 8,
  parameter int GAP_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NCH*WIDTH-1:0]  din,
  input  logic [NCH*CNTW-1:0]   dwell,
  input  logic                  force_vld,
  input  logic [SELW-1:0]       force_sel,
  output logic [WIDTH-1:0]      dout,
  output logic [SELW-1:0]       sel,
  output logic                  switch_pulse
);

`ifdef TSM_GAP_INSERT_EN
  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
`else
  typedef enum logic {IDLE, RUN} state_t;
`endif

  localparam logic [SELW-1:0] LAST  = SELW'(NCH - 1);
  localparam logic [SELW:0]   NCH_W = (SELW + 1)'(NCH);

  state_t            state_q, state_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              pulse_q, pulse_d;
  logic [WIDTH-1:0]  cur_din;
  logic [SELW-1:0]   target;
  logic              force_ok;
`ifdef TSM_GAP_INSERT_EN
  logic [SELW-1:0]   pend_q, pend_d, pend_n;
  logic [GW-1:0]     gcnt_q, gcnt_d;
`endif

  // Counter value to load so that channel k is held max(dwell[k],1) cycles.
  function automatic logic [CNTW-1:0] dwell_load(input logic [NCH*CNTW-1:0] dv,
                                                 input logic [SELW-1:0] k);
    logic [CNTW-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < NCH; i++)
      if (k == SELW'(i)) d = dv[i*CNTW +: CNTW];
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  always_comb begin
    cur_din = '0;
    for (int unsigned i = 0; i < NCH; i++)
      if (sel_q == SELW'(i)) cur_din = din[i*WIDTH +: WIDTH];
  end

  always_comb begin
    assert (NCH >= 2 && NCH <= 16 && (2 ** SELW) >= NCH && GAP_CYC >= 1);
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    pulse_d  = 1'b0;
    target   = sel_q;
    force_ok = force_vld && ({1'b0, force_sel} < NCH_W);
`ifdef TSM_GAP_INSERT_EN
    pend_d   = pend_q;
    pend_n   = pend_q;
    gcnt_d   = gcnt_q;
`endif
    case (state_q)
      IDLE: begin
        dout_d = '0;
        sel_d  = '0;
        cnt_d  = '0;
        if (en) begin
          state_d = RUN;
          cnt_d   = dwell_load(dwell, '0);
          pulse_d = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          dout_d  = '0;
          sel_d   = '0;
          cnt_d   = '0;
        end else begin
          dout_d = cur_din;
          // A valid force takes priority over dwell expiry.
          target = force_ok ? force_sel : ((sel_q == LAST) ? '0 : sel_q + 1'b1);
          if (force_ok || cnt_q == '0) begin
`ifdef TSM_GAP_INSERT_EN
            state_d = GAP;
            pend_d  = target;
            gcnt_d  = GW'(GAP_CYC - 1);
            dout_d  = '0;
`else
            sel_d   = target;
            cnt_d   = dwell_load(dwell, target);
            pulse_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
`ifdef TSM_GAP_INSERT_EN
      GAP: begin
        if (!en) begin
          state_d = IDLE;
          dout_d  = '0;
          sel_d   = '0;
          cnt_d   = '0;
        end else begin
          dout_d = '0;
          pend_n = force_ok ? force_sel : pend_q;
          pend_d = pend_n;
          if (gcnt_q == '0) begin
            state_d = RUN;
            sel_d   = pend_n;
            cnt_d   = dwell_load(dwell, pend_n);
            pulse_d = 1'b1;
          end else begin
            gcnt_d = gcnt_q - 1'b1;
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
        dout_d  = '0;
        sel_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      pulse_q <= 1'b0;
`ifdef TSM_GAP_INSERT_EN
      pend_q  <= '0;
      gcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      pulse_q <= pulse_d;
`ifdef TSM_GAP_INSERT_EN
      pend_q  <= pend_d;
      gcnt_q  <= gcnt_d;
`endif
    end
  end

  assign dout         = dout_q;
  assign sel          = sel_q;
  assign switch_pulse = pulse_q;

endmodule
